piped_sum_sequencer: RTL and testbench
======================================

# piped_sum_sequencer

Iterative reduction controller that sums `N_args` signed arguments by repeatedly applying a single shared pairwise-sum stage to a working register, instead of instantiating a full pipelined adder tree. It sits in the imitator DSP path where many lanes must be summed but throughput is low, trading `clog2(N_args)` cycles of latency for one row of adders. It provides a `we`/`ready` request handshake, a one-cycle `valid` result strobe and a synchronous abort.

## Interface
- `arg_width`, 8, bits per input argument (signed two's complement)
- `N_args`, 5, number of arguments, ≥1
- `levels`, `clog2(N_args)` (0 when `N_args`=1), derived: reduction passes
- `acc_width`, `arg_width + levels`, derived: lane and result width

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in`  in  `N_args*arg_width`  packed arguments, lane i at `[(i+1)*arg_width-1 : i*arg_width]`
- `we`  in  1  start request, accepted only when `ready`=1
- `clear`  in  1  synchronous abort, returns to IDLE
- `ready`  out  1  high in IDLE only
- `sum`  out  `acc_width`  signed result, held until next accepted `we`
- `valid`  out  1  one-cycle strobe, `sum` is new

## Operation
- States: IDLE, REDUCE, DONE.
- IDLE: `ready`=1.
  - On `we`=1, load `work` lanes with sign-extended `in`, and set `cnt`=`N_args`.
  - Next state is REDUCE, or DONE directly if `N_args`=1.
- REDUCE, each cycle:
  - `work[i] <= work[2i] + work[2i+1]` for i < ceil(cnt/2), with lanes ≥ `N_args` read as 0.
  - Lanes ≥ ceil(cnt/2) are written 0.
  - `cnt <= ceil(cnt/2)`.
  - When the new `cnt`=1: `sum <= ` new `work[0]`, and go to DONE.
- DONE: `valid`=1 for exactly this cycle, then IDLE.
- Odd count: the last lane passes through unchanged (it is added to 0).
- Width: all lanes are `acc_width`, so no overflow is possible and no saturation is needed. Sign extension happens at load only.
- `we` while `ready`=0 is ignored. It is not queued.
- `clear` has priority over all transitions:
  - next state is IDLE and `work`/`cnt` are zeroed;
  - `sum` keeps its last value;
  - `valid` is forced 0 the following cycle.
- `clear` and `we` in the same IDLE cycle: `clear` wins and the request is dropped.
- `in` is sampled only on the accepting edge. Later changes have no effect.

## Timing
- Reset (async assert, `reset`=0): state IDLE, `ready`=1, `valid`=0, `sum`=0, `work`=0, `cnt`=0.
- Deassertion is synchronised externally. The block is sensitive to `negedge reset` only for assert.
- Accept edge E:
  - REDUCE occupies cycles E+1 … E+`levels`;
  - DONE (`valid`=1, `sum` valid) is the cycle after edge E+`levels`.
  - For `N_args`=1, DONE is the cycle after E.
- `ready` is low from the cycle after E through the DONE cycle.
- Minimum spacing between accepted requests is `levels`+2 cycles.
- Reset asserted mid-operation aborts immediately and no `valid` is produced.

## Structure
- Shared package `piped_sum_pkg`:
  - `clog2` constant function;
  - state encoding constants `ST_IDLE`/`ST_REDUCE`/`ST_DONE`;
  - derived-width helper `acc_width(arg_width, N_args)`.
- One sub-module, `pair_sum_comb`: a purely combinational pairwise adder over `N_args` lanes of `acc_width`, where output lane i = in 2i + in 2i+1 and unused lanes are 0.
- The FSM, `cnt`, `work` register and output registers live in the top.

## Test plan
- `N_args`=5, `arg_width`=8, all lanes 127, `we` pulse → `valid` 4 cycles after the accept edge (3 REDUCE + DONE), `sum`=635.
- All lanes -128 → `sum`=-640. Lanes {1,-2,3,-4,5} → `sum`=3. In both cases `valid` is high exactly one cycle.
- `we` held high continuously → accepts every 5th cycle (`levels`+2). Changing `in` during REDUCE does not alter the in-flight result.
- `clear` in the second REDUCE cycle → `ready`=1 the next cycle, no `valid`, `sum` keeps its previous value (635 from the first test).
- `reset` low in the middle of REDUCE → immediately `ready`=1, `valid`=0, `sum`=0. After release, a new request {10,10,10,10,10} gives `sum`=50.
- `N_args`=1, `in`=-7 → `valid` in the cycle after the accept edge, `sum`=-7. `N_args`=8, lanes 0..7 → `sum`=28 after 3 REDUCE cycles.

Source files
------------

// File: rtl/piped_sum_pkg.sv
// Shared types and elaboration-time helpers for the iterative pairwise-sum reducer.
package piped_sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int arg_width, input int n_args);
        return arg_width + clog2(n_args);
    endfunction

endpackage

// File: rtl/piped_sum_sequencer_pair_sum_comb.sv
// One row of pairwise adders: output lane i = lane 2i + lane 2i+1, missing lanes are 0.
module pair_sum_comb
    import piped_sum_pkg::*;
#(
    parameter int N_args    = 5,
    parameter int acc_width = 11
) (
    input  logic [N_args*acc_width-1:0] lanes,
    output logic [N_args*acc_width-1:0] sums
);

    for (genvar i = 0; i < N_args; i++) begin : g_lane
        localparam int lo = 2 * i;
        localparam int hi = 2 * i + 1;
        if (hi < N_args) begin : g_pair
            assign sums[i*acc_width +: acc_width] =
                lanes[lo*acc_width +: acc_width] + lanes[hi*acc_width +: acc_width];
        end else if (lo < N_args) begin : g_pass
            assign sums[i*acc_width +: acc_width] = lanes[lo*acc_width +: acc_width];
        end else begin : g_zero
            assign sums[i*acc_width +: acc_width] = '0;
        end
    end

endmodule

// File: rtl/piped_sum_sequencer.sv
// Iterative reduction controller: folds N_args signed lanes through one shared
// pairwise-adder row, halving the live lane count each REDUCE cycle.
module piped_sum_sequencer
    import piped_sum_pkg::*;
#(
    parameter int arg_width = 8,
    parameter int N_args    = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_args*arg_width-1:0]           in,
    input  logic                                  we,
    input  logic                                  clear,
    output logic                                  ready,
    output logic [arg_width+clog2(N_args)-1:0]    sum,
    output logic                                  valid
);

    localparam int levels    = clog2(N_args);
    localparam int acc_width = piped_sum_pkg::acc_width(arg_width, N_args);
    // cnt must hold N_args itself, which never exceeds 2**levels.
    localparam int cnt_w     = levels + 1;

    state_t state, state_nx;

    logic signed [acc_width-1:0] work    [N_args];
    logic signed [acc_width-1:0] work_nx [N_args];
    logic [cnt_w-1:0]            cnt, cnt_nx;
    logic [acc_width-1:0]        sum_nx;
    logic [N_args*acc_width-1:0] work_flat;
    logic [N_args*acc_width-1:0] pair_flat;
    int                          cnt_half;

    always_comb begin
        work_flat = '0;
        for (int i = 0; i < N_args; i++) begin
            work_flat[i*acc_width +: acc_width] = work[i];
        end
    end

    pair_sum_comb #(
        .N_args    (N_args),
        .acc_width (acc_width)
    ) u_pair_sum (
        .lanes (work_flat),
        .sums  (pair_flat)
    );

    // NOTE: nonblocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        work_nx  = work;
        sum_nx   = sum;
        cnt_half = (int'(cnt) + 1) / 2;

        unique case (state)
            ST_IDLE: begin
                if (we) begin
                    for (int i = 0; i < N_args; i++) begin
                        work_nx[i] = acc_width'(signed'(in[i*arg_width +: arg_width]));
                    end
                    cnt_nx = cnt_w'(N_args);
                    if (N_args == 1) begin
                        sum_nx   = work_nx[0];
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                for (int i = 0; i < N_args; i++) begin
                    work_nx[i] = (i < cnt_half) ? signed'(pair_flat[i*acc_width +: acc_width]) : '0;
                end
                cnt_nx = cnt_w'(cnt_half);
                if (cnt_half == 1) begin
                    sum_nx   = work_nx[0];
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start request.
        if (clear) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            sum_nx   = sum;
            for (int i = 0; i < N_args; i++) begin
                work_nx[i] = '0;
            end
        end
    end

    // NOTE: the lane array is reset element by element so an aborted pass leaves no stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            sum <= '0;
            for (int i = 0; i < N_args; i++) begin
                work[i] <= '0;
            end
        end else begin
            cnt  <= cnt_nx;
            sum  <= sum_nx;
            work <= work_nx;
        end
    end

    assign ready = (state == ST_IDLE);
    assign valid = (state == ST_DONE);

endmodule

// File: tb/tb_piped_sum_sequencer.sv
// Directed bench for piped_sum_sequencer: N_args=5 main instance plus N_args=1 and N_args=8 corners.
module tb_piped_sum_sequencer;

    logic clk;
    logic reset;

    logic [39:0] in5;
    logic        we5, clear5, ready5, valid5;
    logic [10:0] sum5;

    logic [7:0]  in1;
    logic        we1, ready1, valid1;
    logic [7:0]  sum1;

    logic [63:0] in8;
    logic        we8, ready8, valid8;
    logic [10:0] sum8;

    int n_checks = 0;
    int n_fail   = 0;

    piped_sum_sequencer #(.arg_width(8), .N_args(5)) dut5 (
        .clk(clk), .reset(reset), .in(in5), .we(we5), .clear(clear5),
        .ready(ready5), .sum(sum5), .valid(valid5)
    );

    piped_sum_sequencer #(.arg_width(8), .N_args(1)) dut1 (
        .clk(clk), .reset(reset), .in(in1), .we(we1), .clear(1'b0),
        .ready(ready1), .sum(sum1), .valid(valid1)
    );

    piped_sum_sequencer #(.arg_width(8), .N_args(8)) dut8 (
        .clk(clk), .reset(reset), .in(in8), .we(we8), .clear(1'b0),
        .ready(ready8), .sum(sum8), .valid(valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pack5(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
        return {a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    // Pulse we on the 5-lane instance and check latency, result and one-cycle valid.
    task automatic req5(input string tag, input logic [39:0] v, input int exp_sum);
        int lat;
        lat = -1;
        in5 = v;
        we5 = 1'b1;
        tick();
        we5 = 1'b0;
        check({tag, "_busy"}, ready5, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (valid5 === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_sum"}, $signed(sum5), exp_sum);
        tick();
        check({tag, "_valid_drop"}, valid5, 0);
        check({tag, "_ready_back"}, ready5, 1);
    endtask

    initial begin
        int          seen;
        int          lat;
        logic [9:0]  vmask, rmask;
        logic [10:0] sum_a, sum_b;

        reset  = 1'b0;
        in5    = '0; we5 = 1'b0; clear5 = 1'b0;
        in1    = '0; we1 = 1'b0;
        in8    = '0; we8 = 1'b0;

        #2;
        check("rst_ready", ready5, 1);
        check("rst_valid", valid5, 0);
        check("rst_sum", sum5, 0);
        check("rst_ready_n1", ready1, 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        req5("pos_max", pack5(127, 127, 127, 127, 127), 635);

        // Abort in the second REDUCE cycle; sum must keep 635.
        in5 = pack5(-128, -128, -128, -128, -128);
        we5 = 1'b1;
        tick();
        we5 = 1'b0;
        tick();
        clear5 = 1'b1;
        tick();
        clear5 = 1'b0;
        check("clr_ready", ready5, 1);
        check("clr_valid", valid5, 0);
        check("clr_sum_hold", $signed(sum5), 635);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid5 === 1'b1) seen++;
        end
        check("clr_no_valid", seen, 0);

        // clear and we in the same IDLE cycle: request dropped.
        clear5 = 1'b1;
        we5    = 1'b1;
        tick();
        clear5 = 1'b0;
        we5    = 1'b0;
        check("clr_we_drop", ready5, 1);

        req5("neg_max", pack5(-128, -128, -128, -128, -128), -640);
        req5("mixed", pack5(1, -2, 3, -4, 5), 3);

        // we held high: accepts every 5 cycles, in-flight result ignores later `in`.
        in5 = pack5(10, 10, 10, 10, 10);
        we5 = 1'b1;
        tick();
        in5   = pack5(1, 1, 1, 1, 1);
        vmask = '0;
        rmask = '0;
        sum_a = '0;
        sum_b = '0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            vmask[i] = valid5;
            rmask[i] = ready5;
            if (i == 3) sum_a = sum5;
            if (i == 8) begin
                sum_b = sum5;
                we5   = 1'b0;
            end
        end
        check("held_valid_mask", vmask, 10'b01_0000_1000);
        check("held_ready_mask", rmask, 10'b10_0001_0000);
        check("held_first_sum", $signed(sum_a), 50);
        check("held_second_sum", $signed(sum_b), 5);

        // Async reset in the middle of REDUCE.
        in5 = pack5(-1, -1, -1, -1, -1);
        we5 = 1'b1;
        tick();
        we5 = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("arst_ready", ready5, 1);
        check("arst_valid", valid5, 0);
        check("arst_sum", sum5, 0);
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid5 === 1'b1) seen++;
        end
        check("arst_no_valid", seen, 0);
        req5("after_rst", pack5(10, 10, 10, 10, 10), 50);

        // Single-argument instance: DONE directly after the accept edge.
        in1 = 8'hF9;
        we1 = 1'b1;
        tick();
        we1 = 1'b0;
        in1 = 8'h05;
        check("n1_valid", valid1, 1);
        check("n1_sum", $signed(sum1), -7);
        tick();
        check("n1_valid_drop", valid1, 0);
        check("n1_ready", ready1, 1);

        // Eight-argument instance: lanes 0..7.
        for (int i = 0; i < 8; i++) in8[i*8 +: 8] = 8'(i);
        we8 = 1'b1;
        tick();
        we8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (valid8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("n8_lat", lat, 3);
        check("n8_sum", $signed(sum8), 28);
        tick();
        check("n8_valid_drop", valid8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
